// File: rtl/qswap_pkg.sv
// ----------------------------------------------------------------------------
// qswap_pkg: shared types and constants for the quadrant-swap controller.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package qswap_pkg;

  localparam int COORD_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_X_MIN = 2'd0;
  localparam logic [1:0] ADDR_X_MAX = 2'd1;
  localparam logic [1:0] ADDR_Y_MIN = 2'd2;
  localparam logic [1:0] ADDR_Y_MAX = 2'd3;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bounds_t;

  // One extra bit on the sum keeps the midpoint exact at the top of the range.
  function automatic logic [COORD_W-1:0] centre(input logic [COORD_W-1:0] lo,
                                                input logic [COORD_W-1:0] hi);
    logic [COORD_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[COORD_W:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/quadrant_swap_ctrl_if.sv
// ----------------------------------------------------------------------------
// quadrant_swap_ctrl_if: configuration port and active-window outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface quadrant_swap_ctrl_if #(
  parameter int COORD_W = qswap_pkg::COORD_W
);
  logic               cfg_wr;
  logic [1:0]         cfg_addr;
  logic [COORD_W-1:0] cfg_wdata;
  logic               commit;
  logic               frame_start;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic [COORD_W-1:0] x_cen;
  logic [COORD_W-1:0] y_cen;
  logic               busy;
  logic               cfg_err;
  logic               apply_done;
  logic [1:0]         rot_phase;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, commit, frame_start,
    input  x_min, x_max, y_min, y_max, x_cen, y_cen,
    input  busy, cfg_err, apply_done, rot_phase
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, commit, frame_start,
    output x_min, x_max, y_min, y_max, x_cen, y_cen,
    output busy, cfg_err, apply_done, rot_phase
  );
endinterface

`default_nettype wire

// File: rtl/frame_step_counter.sv
// ----------------------------------------------------------------------------
// frame_step_counter: advances a 2-bit rotation phase every FRAMES_PER_STEP frames.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_step_counter #(
  parameter int FRAMES_PER_STEP = 60
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       frame_start,
  output logic [1:0]      rot_phase
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      rot_phase <= 2'd0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        rot_phase <= rot_phase + 2'd1;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/quadrant_swap_ctrl.sv
// ----------------------------------------------------------------------------
// quadrant_swap_ctrl: shadow/active window bounds with frame-aligned commit.
// Optional rotation counter enabled by macro QSWAP_ROTATE_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module quadrant_swap_ctrl
  import qswap_pkg::*;
#(
  parameter int COORD_W         = qswap_pkg::COORD_W,
  parameter int DEF_X_MIN       = 0,
  parameter int DEF_X_MAX       = 128,
  parameter int DEF_Y_MIN       = 0,
  parameter int DEF_Y_MAX       = 128,
  parameter int FRAMES_PER_STEP = 60
) (
  input  wire logic           clk,
  input  wire logic           reset,
  quadrant_swap_ctrl_if.slave bus
);

  localparam bounds_t DEF_BOUNDS = '{
    x_min: COORD_W'(DEF_X_MIN),
    x_max: COORD_W'(DEF_X_MAX),
    y_min: COORD_W'(DEF_Y_MIN),
    y_max: COORD_W'(DEF_Y_MAX)
  };
  localparam logic [COORD_W-1:0] DEF_X_CEN = COORD_W'((DEF_X_MIN + DEF_X_MAX) >> 1);
  localparam logic [COORD_W-1:0] DEF_Y_CEN = COORD_W'((DEF_Y_MIN + DEF_Y_MAX) >> 1);

  if (FRAMES_PER_STEP < 1) begin : g_fps_invalid
    $error("FRAMES_PER_STEP must be at least 1");
  end

  state_t             state;
  state_t             state_nx;
  bounds_t            shadow;
  bounds_t            active;
  logic [COORD_W-1:0] x_cen;
  logic [COORD_W-1:0] y_cen;
  logic               cfg_err;
  logic               apply_done;
  logic               wr_ok;
  logic               apply;
  logic               err_set;
  logic               err_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_ok    = 1'b0;
    apply    = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_ok = bus.cfg_wr;
        if (bus.commit) begin
          state_nx = ST_CHECK;
          err_clr  = 1'b1;
        end
      end
      ST_CHECK: begin
        if ((shadow.x_min < shadow.x_max) && (shadow.y_min < shadow.y_max)) begin
          state_nx = ST_PENDING;
        end else begin
          state_nx = ST_IDLE;
          err_set  = 1'b1;
        end
      end
      ST_PENDING: begin
        if (bus.frame_start) begin
          apply    = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= DEF_BOUNDS;
    end else if (wr_ok) begin
      case (bus.cfg_addr)
        ADDR_X_MIN: shadow.x_min <= bus.cfg_wdata;
        ADDR_X_MAX: shadow.x_max <= bus.cfg_wdata;
        ADDR_Y_MIN: shadow.y_min <= bus.cfg_wdata;
        ADDR_Y_MAX: shadow.y_max <= bus.cfg_wdata;
        default:    shadow       <= shadow;
      endcase
    end
  end

  // Bounds and centres move together so the decoder never sees a mixed set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active     <= DEF_BOUNDS;
      x_cen      <= DEF_X_CEN;
      y_cen      <= DEF_Y_CEN;
      apply_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      apply_done <= apply;
      if (apply) begin
        active <= shadow;
        x_cen  <= centre(shadow.x_min, shadow.x_max);
        y_cen  <= centre(shadow.y_min, shadow.y_max);
      end
      if (err_set)      cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;
    end
  end

  assign bus.x_min      = active.x_min;
  assign bus.x_max      = active.x_max;
  assign bus.y_min      = active.y_min;
  assign bus.y_max      = active.y_max;
  assign bus.x_cen      = x_cen;
  assign bus.y_cen      = y_cen;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.cfg_err    = cfg_err;
  assign bus.apply_done = apply_done;

`ifdef QSWAP_ROTATE_EN
  frame_step_counter #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_frame_step_counter (
    .clk         (clk),
    .reset       (reset),
    .frame_start (bus.frame_start),
    .rot_phase   (bus.rot_phase)
  );
`else
  assign bus.rot_phase = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quadrant_swap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_quadrant_swap_ctrl: directed and randomized checks against a transaction model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_quadrant_swap_ctrl;

  localparam int CW  = 9;
  localparam int FPS = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quadrant_swap_ctrl_if #(.COORD_W(CW)) bus ();

  quadrant_swap_ctrl #(
    .COORD_W         (CW),
    .DEF_X_MIN       (0),
    .DEF_X_MAX       (128),
    .DEF_Y_MIN       (0),
    .DEF_Y_MAX       (128),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: shadow and active sets as plain integers.
  int sh[4];
  int act[4];
  bit m_err;
  int frames;

  function automatic int rot_exp();
`ifdef QSWAP_ROTATE_EN
    return (frames / FPS) % 4;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    sh  = '{0, 128, 0, 128};
    act = '{0, 128, 0, 128};
    m_err  = 1'b0;
    frames = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_active(input string tag);
    chk({tag, ".x_min"}, bus.x_min, act[0]);
    chk({tag, ".x_max"}, bus.x_max, act[1]);
    chk({tag, ".x_cen"}, bus.x_cen, (act[0] + act[1]) / 2);
    chk({tag, ".y_min"}, bus.y_min, act[2]);
    chk({tag, ".y_max"}, bus.y_max, act[3]);
    chk({tag, ".y_cen"}, bus.y_cen, (act[2] + act[3]) / 2);
    chk({tag, ".cfg_err"}, bus.cfg_err, m_err);
    chk({tag, ".rot"}, bus.rot_phase, rot_exp());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = 2'(a);
    bus.cfg_wdata = CW'(d);
    tick();
    bus.cfg_wr = 1'b0;
    sh[a] = d;
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    frames++;
  endtask

  // Commit sequence. Optionally writes in the commit cycle, pulses frame_start
  // during the check cycle, and throws ignored writes/commits while pending.
  task automatic run_commit(input string tag, input bit wen, input int wa, input int wd,
                            input bit fs_in_check, input int d, input bit junk,
                            output int busy_cnt);
    bit valid;
    busy_cnt = 0;
    bus.commit = 1'b1;
    if (wen) begin
      bus.cfg_wr = 1'b1; bus.cfg_addr = 2'(wa); bus.cfg_wdata = CW'(wd);
      sh[wa] = wd;
    end
    tick();
    bus.commit = 1'b0;
    bus.cfg_wr = 1'b0;
    m_err = 1'b0;
    chk({tag, ".busy_check"}, bus.busy, 1);
    if (bus.busy === 1'b1) busy_cnt++;
    valid = (sh[0] < sh[1]) && (sh[2] < sh[3]);
    bus.frame_start = fs_in_check;
    tick();
    bus.frame_start = 1'b0;
    if (fs_in_check) frames++;
    chk({tag, ".no_apply_in_check"}, bus.apply_done, 0);
    if (!valid) begin
      m_err = 1'b1;
      chk({tag, ".busy_rejected"}, bus.busy, 0);
      chk_active({tag, ".rejected"});
      return;
    end
    chk({tag, ".busy_pending"}, bus.busy, 1);
    if (bus.busy === 1'b1) busy_cnt++;
    for (int i = 0; i < d; i++) begin
      if (junk) begin
        bus.cfg_wr    = 1'b1;
        bus.cfg_addr  = 2'($urandom_range(0, 3));
        bus.cfg_wdata = CW'($urandom_range(0, 511));
        bus.commit    = 1'b1;
      end
      tick();
      bus.cfg_wr = 1'b0;
      bus.commit = 1'b0;
      chk({tag, ".hold"}, bus.apply_done, 0);
      if (bus.busy === 1'b1) busy_cnt++;
    end
    frame_pulse();
    act = sh;
    chk({tag, ".apply_done"}, bus.apply_done, 1);
    chk({tag, ".busy_after"}, bus.busy, 0);
    chk_active({tag, ".applied"});
    tick();
    chk({tag, ".apply_pulse_end"}, bus.apply_done, 0);
  endtask

  initial begin
    int bc;
    int a;
    int b;
    reset           = 1'b1;
    bus.cfg_wr      = 1'b0;
    bus.cfg_addr    = 2'd0;
    bus.cfg_wdata   = '0;
    bus.commit      = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset values
    chk("reset.busy", bus.busy, 0);
    chk("reset.apply_done", bus.apply_done, 0);
    chk_active("reset");

    // Rotation stepping from a clean counter
    for (int n = 1; n <= 13; n++) begin
      frame_pulse();
      chk($sformatf("rot.pulse%0d", n), bus.rot_phase, rot_exp());
    end

    // Basic commit with frame_start arriving later; last write shares the commit cycle
    wr(0, 10); wr(1, 50); wr(2, 20);
    run_commit("basic", 1'b1, 3, 100, 1'b0, 4, 1'b0, bc);
    chk("basic.busy_cycles", bc, 6);

    // Rejected set leaves active set alone
    wr(0, 200); wr(1, 128); wr(2, 0); wr(3, 128);
    run_commit("reject", 1'b0, 0, 0, 1'b0, 0, 1'b0, bc);
    chk("reject.busy_idle", bus.busy, 0);

    // Writes and commits while pending are ignored; frame_start in CHECK does not apply
    wr(0, 30);
    run_commit("pending_junk", 1'b0, 0, 0, 1'b1, 3, 1'b1, bc);

    // Top-of-range centre and equal-bounds rejection
    wr(0, 510); wr(1, 511); wr(2, 0); wr(3, 511);
    run_commit("edge_hi", 1'b0, 0, 0, 1'b0, 0, 1'b0, bc);
    wr(2, 511);
    run_commit("edge_eq", 1'b0, 0, 0, 1'b0, 1, 1'b0, bc);

    // Randomized commits with interleaved idle frames
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k += 2) begin
        a = $urandom_range(0, 510);
        b = $urandom_range(a + 1, 511);
        if ($urandom_range(0, 9) < 2) begin
          wr(k, b); wr(k + 1, ($urandom_range(0, 1) == 1) ? b : a);
        end else begin
          wr(k, a); wr(k + 1, b);
        end
      end
      run_commit($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 511),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), bc);
      for (int f = 0; f < int'($urandom_range(0, 2)); f++) frame_pulse();
      chk($sformatf("rnd%0d.idle_rot", it), bus.rot_phase, rot_exp());
    end

    // Asynchronous reset while pending
    wr(0, 7); wr(1, 77); wr(2, 8); wr(3, 88);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    chk("areset.pending", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("areset.busy", bus.busy, 0);
    chk_active("areset");
    tick();
    #1;
    reset = 1'b0;
    frame_pulse();
    chk("areset.no_apply", bus.apply_done, 0);
    chk_active("areset.after_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
